// File: rtl/axis_fib_pkg.sv
// Shared definitions for the AXIS <-> FIFO interface bridge controllers:
// count-word field layout, controller state encodings and strobe width.
package axis_fib_pkg;

    localparam int STRB_WIDTH = 32;

    localparam int BCNT_LSB   = 16;
    localparam int BCNT_MSB   = 31;
    localparam int FLAG_PERR  = 0;
    localparam int FLAG_TUSER = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_DROP  = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_FRAME = 2'd1,
        TX_DROP  = 2'd2
    } tx_state_e;

    // Byte count lands in [31:16], status flags in [3:0], everything else zero.
    function automatic logic [63:0] pack_count_word(input logic [15:0] bcnt,
                                                    input logic [3:0]  flags);
        logic [63:0] w;
        w = '0;
        w[BCNT_MSB:BCNT_LSB]   = bcnt;
        w[FLAG_DROP:FLAG_PERR] = flags;
        return w;
    endfunction

endpackage

// File: rtl/strb_popcnt.sv
// Byte-enable analysis for one beat: number of set strobes and whether the
// set strobes form a single run starting at bit 0.
module strb_popcnt (
    input  logic [axis_fib_pkg::STRB_WIDTH-1:0] strb_i,
    output logic [5:0]                          cnt_o,
    output logic                                contig_o
);
    import axis_fib_pkg::*;

    logic [5:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            cnt = cnt + {5'd0, strb_i[i]};
        end
    end

    // A run of ones from bit 0 has no set bit left after adding one and masking.
    assign contig_o = ((strb_i & (strb_i + STRB_WIDTH'(1))) == '0);
    assign cnt_o    = cnt;

endmodule

// File: rtl/axis2fib_txctrl.sv
// Transmit AXIS-to-FIB bridge: writes accepted beats to the data FIFO and one
// byte-count/status word per frame to the count FIFO.
module axis2fib_txctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int BCNT_WIDTH = 64,
    parameter int STRB_WIDTH = 32
) (
    input  logic                  tx_mac_aclk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_axis_mac_tdata,
    input  logic                  tx_axis_mac_tvalid,
    input  logic                  tx_axis_mac_tlast,
    input  logic                  tx_axis_mac_tuser,
    input  logic [STRB_WIDTH-1:0] tx_axis_mac_tstrb,
    output logic                  tx_axis_mac_tready,
    input  logic                  tx_axis_compatible_mode,
    output logic                  wren_df,
    output logic [DATA_WIDTH-1:0] datain_df,
    input  logic                  wrafull_df,
    output logic                  wren_cf,
    output logic [BCNT_WIDTH-1:0] datain_cf,
    input  logic                  wrafull_cf,
    output logic [31:0]           frm_cnt,
    output logic [15:0]           err_cnt
);
    import axis_fib_pkg::*;

    tx_state_e             state_q;
    logic [15:0]           bcnt_q, bcnt_d;
    logic [3:0]            flags_q, flags_d;
    logic                  wren_df_q, wren_cf_q;
    logic [DATA_WIDTH-1:0] datain_df_q;
    logic [BCNT_WIDTH-1:0] datain_cf_q;
    logic [31:0]           frm_cnt_q;
    logic [15:0]           err_cnt_q;

    logic                  space_ok, accept, frame_start, write_beat, drop_beat, beat_perr;
    logic [5:0]            beat_cnt;
    logic                  beat_contig;
    logic [16:0]           sum;
    logic [15:0]           base_bcnt;
    logic [3:0]            base_flags;

    strb_popcnt u_popcnt (
        .strb_i  (tx_axis_mac_tstrb),
        .cnt_o   (beat_cnt),
        .contig_o(beat_contig)
    );

    assign space_ok           = !wrafull_df && !wrafull_cf;
    assign tx_axis_mac_tready = !reset && (tx_axis_compatible_mode || space_ok);
    assign accept             = tx_axis_mac_tvalid && tx_axis_mac_tready;

    // Any beat seen in IDLE starts a new frame, so accumulation restarts from
    // zero with no bubble after a preceding tlast.
    always_comb begin
        frame_start = (state_q == TX_IDLE);
        base_bcnt   = frame_start ? 16'd0 : bcnt_q;
        base_flags  = frame_start ? 4'd0 : flags_q;
        write_beat  = accept && (state_q != TX_DROP) && space_ok;
        drop_beat   = accept && !write_beat;
        beat_perr   = tx_axis_mac_tlast ? (!beat_contig || (beat_cnt == 6'd0))
                                        : (beat_cnt != 6'd32);
        sum         = {1'b0, base_bcnt} + {11'd0, beat_cnt};

        bcnt_d = base_bcnt;
        if (write_beat) begin
            bcnt_d = sum[16] ? 16'hFFFF : sum[15:0];
        end
        flags_d             = base_flags;
        flags_d[FLAG_PERR]  = base_flags[FLAG_PERR]  | beat_perr;
        flags_d[FLAG_TUSER] = base_flags[FLAG_TUSER] | tx_axis_mac_tuser;
        flags_d[FLAG_OVF]   = base_flags[FLAG_OVF]   | (write_beat && sum[16]);
        flags_d[FLAG_DROP]  = base_flags[FLAG_DROP]  | drop_beat;
    end

    always_ff @(posedge tx_mac_aclk or posedge reset) begin
        if (reset) begin
            state_q     <= TX_IDLE;
            bcnt_q      <= '0;
            flags_q     <= '0;
            wren_df_q   <= 1'b0;
            datain_df_q <= '0;
            wren_cf_q   <= 1'b0;
            datain_cf_q <= '0;
            frm_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            wren_df_q <= write_beat;
            if (write_beat) begin
                datain_df_q <= tx_axis_mac_tdata;
            end
            // The count word goes out even if the count FIFO just went almost
            // full: the two-entry margin always leaves room for it.
            wren_cf_q <= accept && tx_axis_mac_tlast;
            if (accept) begin
                bcnt_q  <= bcnt_d;
                flags_q <= flags_d;
                if (tx_axis_mac_tlast) begin
                    state_q     <= TX_IDLE;
                    datain_cf_q <= BCNT_WIDTH'(pack_count_word(bcnt_d, flags_d));
                    frm_cnt_q   <= frm_cnt_q + 32'd1;
                    if ((flags_d != 4'd0) && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                end else if (drop_beat) begin
                    state_q <= TX_DROP;
                end else begin
                    state_q <= TX_FRAME;
                end
            end
        end
    end

    assign wren_df   = wren_df_q;
    assign datain_df = datain_df_q;
    assign wren_cf   = wren_cf_q;
    assign datain_cf = datain_cf_q;
    assign frm_cnt   = frm_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axis2fib_txctrl.sv
// Self-checking bench for axis2fib_txctrl: directed frames from the test plan
// followed by randomized frames, all checked against a frame-level model.
module tb_axis2fib_txctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] tdata = '0;
    logic         tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
    logic [31:0]  tstrb = '0;
    logic         tready;
    logic         compat = 1'b0;
    logic         wrenDf, wrenCf;
    logic [255:0] datainDf;
    logic [63:0]  datainCf;
    logic         wrafullDf = 1'b0, wrafullCf = 1'b0;
    logic [31:0]  frmCnt;
    logic [15:0]  errCnt;

    int checks = 0;
    int errors = 0;

    // Frame-level reference model state
    bit           mInFrame, mDropping, mPerr, mTuser, mDrop;
    int           mBytes;
    bit           expWrenDf, expWrenCf;
    logic [255:0] expDataDf;
    logic [63:0]  expCw;
    logic [31:0]  expFrm;
    logic [15:0]  expErr;

    logic [63:0]  cwSeen[$];
    int           wrenDfSeen;

    axis2fib_txctrl dut (
        .tx_mac_aclk            (clk),
        .reset                  (rst),
        .tx_axis_mac_tdata      (tdata),
        .tx_axis_mac_tvalid     (tvalid),
        .tx_axis_mac_tlast      (tlast),
        .tx_axis_mac_tuser      (tuser),
        .tx_axis_mac_tstrb      (tstrb),
        .tx_axis_mac_tready     (tready),
        .tx_axis_compatible_mode(compat),
        .wren_df                (wrenDf),
        .datain_df              (datainDf),
        .wrafull_df             (wrafullDf),
        .wren_cf                (wrenCf),
        .datain_cf              (datainCf),
        .wrafull_cf             (wrafullCf),
        .frm_cnt                (frmCnt),
        .err_cnt                (errCnt)
    );

    always #5 clk = ~clk;

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strbMask(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic [255:0] randData();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [63:0] getCw(input int i);
        return (cwSeen.size() > i) ? cwSeen[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic modelClear();
        mInFrame = 0; mDropping = 0; mPerr = 0; mTuser = 0; mDrop = 0; mBytes = 0;
        expWrenDf = 0; expWrenCf = 0; expDataDf = '0; expCw = '0; expFrm = '0; expErr = '0;
    endtask

    // Applies the frame rules to whatever the bench drove for this clock edge.
    task automatic modelEdge();
        bit       spaceOk, acc, perrBeat, ovf;
        int       n;
        bit [3:0] flags;
        expWrenDf = 0;
        expWrenCf = 0;
        if (rst) return;
        spaceOk = !wrafullDf && !wrafullCf;
        acc = tvalid && (compat || spaceOk);
        if (!acc) return;
        if (!mInFrame) begin
            mBytes = 0; mPerr = 0; mTuser = 0; mDrop = 0; mDropping = 0;
        end
        n = $countones(tstrb);
        perrBeat = tlast ? (n == 0 || tstrb != strbMask(n)) : (tstrb != 32'hFFFF_FFFF);
        mPerr  = mPerr | perrBeat;
        mTuser = mTuser | tuser;
        if (!mDropping && spaceOk) begin
            mBytes += n;
            expWrenDf = 1;
            expDataDf = tdata;
        end else begin
            mDrop = 1;
            mDropping = 1;
        end
        if (tlast) begin
            ovf   = (mBytes > 65535);
            flags = {mDrop, ovf, mTuser, mPerr};
            expCw = {32'd0, 16'(ovf ? 65535 : mBytes), 12'd0, flags};
            expWrenCf = 1;
            expFrm = expFrm + 1;
            if (flags != 0 && expErr != 16'hFFFF) expErr = expErr + 1;
            mInFrame = 0;
        end else begin
            mInFrame = 1;
        end
    endtask

    // One clock cycle: drive at the falling edge, check tready, model the
    // rising edge, then check registered outputs at the next falling edge.
    task automatic applyStimulus(input bit v, input bit l, input bit u, input logic [31:0] s,
                                 input logic [255:0] d, input bit afDf, input bit afCf, input bit cm);
        tvalid = v; tlast = l; tuser = u; tstrb = s; tdata = d;
        wrafullDf = afDf; wrafullCf = afCf; compat = cm;
        #1;
        checkOutput("tready", tready, !rst && (cm || (!afDf && !afCf)));
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("wren_df", wrenDf, expWrenDf);
        checkOutput("datain_df", datainDf, expDataDf);
        checkOutput("wren_cf", wrenCf, expWrenCf);
        checkOutput("datain_cf", datainCf, expCw);
        checkOutput("frm_cnt", frmCnt, expFrm);
        checkOutput("err_cnt", errCnt, expErr);
        if (wrenCf) cwSeen.push_back(datainCf);
        if (wrenDf) wrenDfSeen++;
    endtask

    task automatic idleCycle(input bit cm);
        applyStimulus(0, 0, 0, 32'h0, '0, 0, 0, cm);
    endtask

    task automatic resetDut();
        rst = 1;
        modelClear();
        idleCycle(0);
        idleCycle(0);
        rst = 0;
        cwSeen.delete();
        wrenDfSeen = 0;
    endtask

    initial begin
        int nBeats;
        bit cm, af, last, accepted;
        logic [31:0] s;
        modelClear();
        @(negedge clk);

        // Two full beats, 64 bytes
        resetDut();
        applyStimulus(1, 0, 0, 32'hFFFF_FFFF, randData(), 0, 0, 0);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, randData(), 0, 0, 0);
        idleCycle(0);
        checkOutput("plan1 wren_df pulses", wrenDfSeen, 2);
        checkOutput("plan1 count word", getCw(0), 64'h0000_0000_0040_0000);
        checkOutput("plan1 frm_cnt", frmCnt, 1);

        // 61-byte frame then back-to-back 1-byte frame
        resetDut();
        applyStimulus(1, 0, 0, 32'hFFFF_FFFF, randData(), 0, 0, 0);
        applyStimulus(1, 1, 0, 32'h1FFF_FFFF, randData(), 0, 0, 0);
        checkOutput("plan2 tready no bubble", tready, 1);
        applyStimulus(1, 1, 0, 32'h0000_0001, randData(), 0, 0, 0);
        idleCycle(0);
        checkOutput("plan2 word count", cwSeen.size(), 2);
        checkOutput("plan2 first word", getCw(0), 64'h0000_0000_003D_0000);
        checkOutput("plan2 second word", getCw(1), 64'h0000_0000_0001_0000);

        // Partial strobe on a non-last beat
        resetDut();
        applyStimulus(1, 0, 0, 32'h0000_FFFF, randData(), 0, 0, 0);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, randData(), 0, 0, 0);
        idleCycle(0);
        checkOutput("plan3 perr bit", getCw(0), 64'h0000_0000_0030_0001);
        checkOutput("plan3 err_cnt", errCnt, 1);

        // Backpressure mid-frame, normal mode
        resetDut();
        applyStimulus(1, 0, 0, 32'hFFFF_FFFF, randData(), 0, 0, 0);
        applyStimulus(1, 0, 0, 32'hFFFF_FFFF, randData(), 1, 0, 0);
        checkOutput("plan4 no write while full", wrenDf, 0);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, randData(), 0, 0, 0);
        idleCycle(0);
        checkOutput("plan4 wren_df pulses", wrenDfSeen, 2);
        checkOutput("plan4 count word", getCw(0), 64'h0000_0000_0040_0000);

        // Low space mid-frame, compatible mode: remainder dropped
        resetDut();
        applyStimulus(1, 0, 0, 32'hFFFF_FFFF, randData(), 0, 0, 1);
        applyStimulus(1, 0, 0, 32'hFFFF_FFFF, randData(), 1, 0, 1);
        applyStimulus(1, 0, 0, 32'hFFFF_FFFF, randData(), 0, 0, 1);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, randData(), 0, 0, 1);
        idleCycle(1);
        checkOutput("plan5 wren_df pulses", wrenDfSeen, 1);
        checkOutput("plan5 count word", getCw(0), 64'h0000_0000_0020_0008);

        // Asynchronous reset in the middle of a frame
        resetDut();
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, randData(), 0, 0, 0);
        applyStimulus(1, 0, 0, 32'hFFFF_FFFF, randData(), 0, 0, 0);
        #2 rst = 1;
        #1;
        checkOutput("async rst wren_df", wrenDf, 0);
        checkOutput("async rst datain_df", datainDf, 0);
        checkOutput("async rst datain_cf", datainCf, 0);
        checkOutput("async rst frm_cnt", frmCnt, 0);
        checkOutput("async rst tready", tready, 0);
        modelClear();
        cwSeen.delete();
        @(negedge clk);
        rst = 0;
        idleCycle(0);
        checkOutput("post rst frm_cnt", frmCnt, 0);
        applyStimulus(1, 1, 0, 32'h0000_000F, randData(), 0, 0, 0);
        idleCycle(0);
        checkOutput("post rst count word", getCw(0), 64'h0000_0000_0004_0000);
        checkOutput("post rst frm_cnt one", frmCnt, 1);

        // Randomized frames with idle gaps, backpressure and mode changes
        resetDut();
        for (int f = 0; f < 200; f++) begin
            nBeats = $urandom_range(1, 6);
            cm = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < nBeats; b++) begin
                last = (b == nBeats - 1);
                if (last) s = ($urandom_range(0, 4) == 0) ? $urandom : strbMask($urandom_range(1, 32));
                else      s = ($urandom_range(0, 6) == 0) ? $urandom : 32'hFFFF_FFFF;
                if ($urandom_range(0, 3) == 0) idleCycle(cm);
                accepted = 0;
                for (int t = 0; t < 20 && !accepted; t++) begin
                    af = (t < 10) && ($urandom_range(0, 7) == 0);
                    accepted = cm || !af;
                    if ($urandom_range(0, 1) == 0)
                        applyStimulus(1, last, ($urandom_range(0, 15) == 0), s, randData(), af, 0, cm);
                    else
                        applyStimulus(1, last, ($urandom_range(0, 15) == 0), s, randData(), 0, af, cm);
                end
            end
        end
        idleCycle(0);
        idleCycle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis2fib_txctrl.md
# axis2fib_txctrl

Transmit-side AXI-Stream bridge: accepts frames from an AXIS master on a 256-bit slave port, writes each beat into the transmit data FIFO, and, at end of frame, writes one byte-count/status word into the transmit count FIFO. The count word uses the same format the receive path consumes: byte count in [31:16]. The block sits between the user AXIS transmit interface and the FIFO interface bridge (FIB) toward the MAC. Each frame yields exactly one count word, written after its last data word.

## Interface
- DATA_WIDTH, 256, tdata / data FIFO width
- BCNT_WIDTH, 64, count FIFO word width
- STRB_WIDTH, 32, tstrb width (DATA_WIDTH/8)
- tx_mac_aclk  in  1  AXIS clock; the only clock
- reset  in  1  asynchronous, active-high reset
- tx_axis_mac_tdata  in  256  beat data
- tx_axis_mac_tvalid  in  1  beat valid
- tx_axis_mac_tlast  in  1  last beat of frame
- tx_axis_mac_tuser  in  1  source-flagged frame error
- tx_axis_mac_tstrb  in  32  byte enables, contiguous from bit 0
- tx_axis_mac_tready  out  1  beat accepted when high with tvalid
- tx_axis_compatible_mode  in  1  1 = tready forced high; beats dropped when FIFO space is low
- wren_df  out  1  data FIFO write enable
- datain_df  out  256  data FIFO write data
- wrafull_df  in  1  data FIFO almost full (≤2 free entries)
- wren_cf  out  1  count FIFO write enable
- datain_cf  out  64  count FIFO write data
- wrafull_cf  in  1  count FIFO almost full (≤2 free entries)
- frm_cnt  out  32  frames committed, wrapping
- err_cnt  out  16  frames with any error bit set, saturating at FFFF

## Operation
- States:
  - TX_IDLE: awaiting first beat.
  - TX_FRAME: mid-frame.
  - TX_DROP: discarding the rest of a frame (compatible mode only).
- space_ok = !wrafull_df & !wrafull_cf.
- tready = compatible_mode ? 1 : space_ok. accept = tvalid & tready.
- Beat write: on accept, with state ≠ TX_DROP and space_ok, wren_df <= 1 and datain_df <= tdata.
- Beat byte count = popcount(tstrb), 0..32. Running count bcnt is 16 bits, cleared at frame start.
  - bcnt saturates at FFFF; saturation sets ovf.
- Protocol error perr is set by either:
  - a non-last beat with tstrb ≠ FFFF_FFFF, or
  - a last beat with non-contiguous tstrb (tstrb & (tstrb+1) ≠ 0) or tstrb = 0.
- Count word: [63:32]=0, [31:16]=final bcnt, [15:4]=0, [3]=drop, [2]=ovf, [1]=OR of tuser over the frame, [0]=perr.
- Count word is written on the cycle after the accepted tlast beat: wren_cf=1 for one cycle.
- Transitions:
  - IDLE → FRAME: accepted non-last beat.
  - IDLE stays IDLE on a single-beat frame; its count word is still written.
  - FRAME → IDLE: accepted tlast.
  - Compatible mode, accepted beat while !space_ok: that beat is dropped, drop flag set, → TX_DROP.
  - TX_DROP: discards beats until tlast, then writes the count word with bcnt covering written beats only, and drop=1. If the dropping beat was tlast, the count word is written directly and the state returns to IDLE.
  - Count word after a drop is written regardless of wrafull_cf. The ≤2-entry margin guarantees room.
- frm_cnt increments with every wren_cf. err_cnt increments when count word [3:0] ≠ 0.

## Timing
- Reset values: tready 0 while reset asserted, then follows the rule above. wren_df 0, datain_df 0, wren_cf 0, datain_cf 0, frm_cnt 0, err_cnt 0, state TX_IDLE, bcnt 0.
- Latency: accepted beat → wren_df one cycle later. Accepted tlast → wren_cf one cycle later, same cycle as the last wren_df.
- tready is combinational from wrafull_* and compatible_mode. No dependence on tvalid.
- Back-to-back frames: a first beat in the cycle after tlast is legal. bcnt restarts from that beat's popcount, with no bubble.
- Reset mid-frame: all state cleared asynchronously, no count word is written. Data and count FIFOs share this reset.
- tvalid low mid-frame: state and bcnt hold.

## Structure
- Shared package axis_fib_pkg:
  - count-word field positions (BCNT_LSB=16, BCNT_MSB=31, flag bit indices)
  - state encodings
  - STRB_WIDTH
  - shared with axis2fib_rxctrl
- One sub-module, strb_popcnt: combinational 32-bit popcount plus contiguity check, outputs cnt[5:0] and contig.

## Test plan
- Single 64-byte frame, 2 beats with tstrb FFFF_FFFF, compatible_mode=0:
  - 2 wren_df pulses.
  - datain_cf = 0000_0000_0040_0000.
  - frm_cnt=1.
- 61-byte frame, last tstrb=1FFF_FFFF, followed by a 1-byte frame (tstrb=1, tlast) in the next cycle:
  - count words 003D_0000 then 0001_0000.
  - no bubble on tready.
- Non-last beat with tstrb=0000_FFFF:
  - count word bit0=1.
  - err_cnt=1.
- wrafull_df=1 mid-frame, compatible_mode=0:
  - tready=0 that cycle, no wren_df, frame resumes intact when wrafull_df drops.
- wrafull_df=1 mid-frame, compatible_mode=1:
  - beats dropped until tlast.
  - count word bit3=1, bcnt = bytes written only.
- Async reset asserted mid-frame:
  - outputs go to 0 immediately.
  - next frame counts from 0, frm_cnt=0 before it.
